izhikevich_array: RTL and testbench

Time-multiplexed Izhikevich neuron array: one shared datapath updates `NEURONS` neurons sequentially, one neuron per clock, per `start` pulse (one simulation timestep). Per-neuron membrane voltage `v` and recovery `w` live in internal register arrays. Spike flags, a `done` pulse and a random-access state readout port are provided. It replaces the single-neuron core in network-level designs, with a corrected reset rule (`w += d`) and optional saturating arithmetic.

---
 rtl/izhikevich_array.sv | 220 ++++++++++++++++++++++
 tb/tb_izhikevich_array.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/izhikevich_array.sv
// ----------------------------------------------------------------------------
// izhikevich_array
//
// Time-multiplexed Izhikevich neuron array. A single shared fixed-point
// datapath updates NEURONS neurons one per clock for every start pulse
// (one simulation timestep). Membrane voltage v and recovery w for each
// neuron live in internal register arrays. After reset an INIT sweep loads
// v_init/w_init into every neuron before the block becomes idle.
//
// Optional feature macro: IZH_SATURATE_EN
//   defined   -> every product and sum saturates to the signed N-bit range
//   undefined -> two's-complement wrap (low N bits kept)
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             one-cycle pulse starting a sweep, honoured only in IDLE
//   v_init, w_init    initial neuron state written by the INIT sweep
//   v_th, step, a, b,
//   c, d              shared model parameters, held stable while busy
//   cur_idx           index of the neuron processed this cycle
//   cur_i             input current for neuron cur_idx (same-cycle)
//   rd_idx            readout index
//   rd_v, rd_w        registered state of neuron rd_idx (1-cycle latency)
//   spikes            per-neuron spike flags from the last sweep
//   busy              high during INIT or UPDATE
//   done              one-cycle pulse at the end of an UPDATE sweep
// ----------------------------------------------------------------------------
module izhikevich_array #(
    parameter int N       = 32,
    parameter int Q       = 16,
    parameter int NEURONS = 8,
    parameter int IW      = $clog2(NEURONS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [N-1:0] v_init,
    input  logic signed [N-1:0] w_init,
    input  logic signed [N-1:0] v_th,
    input  logic signed [N-1:0] step,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic signed [N-1:0] c,
    input  logic signed [N-1:0] d,
    output logic [IW-1:0]       cur_idx,
    input  logic signed [N-1:0] cur_i,
    input  logic [IW-1:0]       rd_idx,
    output logic signed [N-1:0] rd_v,
    output logic signed [N-1:0] rd_w,
    output logic [NEURONS-1:0]  spikes,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPDATE} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NEURONS - 1);

    // Model constants in QN.Q format; 0.04 is rounded to the nearest LSB.
    localparam logic signed [N-1:0] K_004 = N'((4 * (longint'(1) << Q) + 50) / 100);
    localparam logic signed [N-1:0] K_5   = N'(longint'(5) << Q);
    localparam logic signed [N-1:0] K_140 = N'(longint'(140) << Q);

    localparam logic signed [N-1:0] MAX_N = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

    state_t              state;
    logic signed [N-1:0] v_mem [NEURONS];
    logic signed [N-1:0] w_mem [NEURONS];

    logic signed [N-1:0] v_k;
    logic signed [N-1:0] w_k;
    logic                spike_k;
    logic signed [N-1:0] v_poly;
    logic signed [N-1:0] w_drive;
    logic signed [N-1:0] v_next;
    logic signed [N-1:0] w_next;

    // Fixed-point multiply: full 2N-bit product, arithmetic shift by Q
    // (floor), then either clamp or keep the low N bits.
    function automatic logic signed [N-1:0] fx_mul(input logic signed [N-1:0] x,
                                                   input logic signed [N-1:0] y);
        logic signed [2*N-1:0] prod;
        logic signed [2*N-1:0] shifted;
        prod    = (2*N)'(x) * (2*N)'(y);
        shifted = prod >>> Q;
`ifdef IZH_SATURATE_EN
        if (shifted > (2*N)'(MAX_N))
            fx_mul = MAX_N;
        else if (shifted < (2*N)'(MIN_N))
            fx_mul = MIN_N;
        else
            fx_mul = N'(shifted);
`else
        fx_mul = N'(shifted);
`endif
    endfunction

    // Sum and difference share the same overflow policy as the multiply.
    function automatic logic signed [N-1:0] fx_add(input logic signed [N-1:0] x,
                                                   input logic signed [N-1:0] y);
`ifdef IZH_SATURATE_EN
        logic signed [N:0] sum;
        sum = (N+1)'(x) + (N+1)'(y);
        if (sum[N] != sum[N-1])
            fx_add = sum[N] ? MIN_N : MAX_N;
        else
            fx_add = N'(sum);
`else
        fx_add = x + y;
`endif
    endfunction

    function automatic logic signed [N-1:0] fx_sub(input logic signed [N-1:0] x,
                                                   input logic signed [N-1:0] y);
`ifdef IZH_SATURATE_EN
        logic signed [N:0] diff;
        diff = (N+1)'(x) - (N+1)'(y);
        if (diff[N] != diff[N-1])
            fx_sub = diff[N] ? MIN_N : MAX_N;
        else
            fx_sub = N'(diff);
`else
        fx_sub = x - y;
`endif
    endfunction

    assign v_k     = v_mem[cur_idx];
    assign w_k     = w_mem[cur_idx];
    assign spike_k = (v_k >= v_th);

    // Shared neuron datapath. Products are evaluated left to right, so
    // 0.04*v*v is (0.04*v)*v and step*a*(b*v-w) is (step*a)*(b*v-w).
    always_comb begin
        v_poly  = fx_add(fx_mul(fx_mul(K_004, v_k), v_k), fx_mul(K_5, v_k));
        v_poly  = fx_add(v_poly, K_140);
        v_poly  = fx_add(fx_sub(v_poly, w_k), cur_i);
        w_drive = fx_mul(fx_mul(step, a), fx_sub(fx_mul(b, v_k), w_k));
        if (spike_k) begin
            v_next = c;
            w_next = fx_add(w_k, d);
        end else begin
            v_next = fx_add(v_k, fx_mul(step, v_poly));
            w_next = fx_add(w_k, w_drive);
        end
    end

    // Sweep sequencer: INIT walks every index once after reset, IDLE waits
    // for start, UPDATE walks every index once per timestep. A start seen
    // while done is still high belongs to the tail of the previous sweep
    // and is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_INIT;
            cur_idx <= '0;
            spikes  <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_INIT: begin
                    if (cur_idx == LAST_IDX) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        cur_idx <= '0;
                    end else begin
                        cur_idx <= cur_idx + IW'(1);
                    end
                end
                S_IDLE: begin
                    if (start && !done) begin
                        state   <= S_UPDATE;
                        busy    <= 1'b1;
                        cur_idx <= '0;
                        spikes  <= '0;
                    end
                end
                S_UPDATE: begin
                    spikes[cur_idx] <= spike_k;
                    if (cur_idx == LAST_IDX) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cur_idx <= '0;
                    end else begin
                        cur_idx <= cur_idx + IW'(1);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Neuron state arrays carry no reset; INIT rewrites every entry once
    // reset is released. While reset is held the sequencer sits in INIT at
    // index 0, so the only write is a harmless reload of neuron 0.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            v_mem[cur_idx] <= v_init;
            w_mem[cur_idx] <= w_init;
        end else if (state == S_UPDATE) begin
            v_mem[cur_idx] <= v_next;
            w_mem[cur_idx] <= w_next;
        end
    end

    // Registered readout; a neuron written on the same edge shows its
    // pre-write contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_v <= '0;
            rd_w <= '0;
        end else begin
            rd_v <= v_mem[rd_idx];
            rd_w <= w_mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_izhikevich_array.sv
// ----------------------------------------------------------------------------
// tb_izhikevich_array
//
// Self-checking bench for izhikevich_array. A behavioural model keeps every
// neuron's v/w as plain integers and applies the neuron equations with
// 64-bit integer arithmetic; DUT readouts, spike flags and sweep timing are
// compared against it and against hand-derived constants for the directed
// cases. Honours IZH_SATURATE_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_izhikevich_array;

    localparam int N       = 32;
    localparam int Q       = 16;
    localparam int NEURONS = 8;
    localparam int IW      = 3;
    localparam int ONE     = 1 << Q;

    localparam int K004 = 2621;
    localparam int K5   = 5 * ONE;
    localparam int K140 = 140 * ONE;

    logic                clk   = 1'b0;
    logic                rst   = 1'b1;
    logic                start = 1'b0;
    logic signed [N-1:0] v_init, w_init, v_th, step, a, b, c, d;
    logic signed [N-1:0] cur_i;
    logic [IW-1:0]       cur_idx;
    logic [IW-1:0]       rd_idx;
    logic signed [N-1:0] rd_v, rd_w;
    logic [NEURONS-1:0]  spikes;
    logic                busy, done;

    logic signed [N-1:0] cur_tab [NEURONS];

    int                  passed = 0;
    int                  total  = 0;

    int                  mv [NEURONS];
    int                  mw [NEURONS];
    logic [NEURONS-1:0]  mspk;

    izhikevich_array #(.N(N), .Q(Q), .NEURONS(NEURONS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .v_init  (v_init),
        .w_init  (w_init),
        .v_th    (v_th),
        .step    (step),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .cur_idx (cur_idx),
        .cur_i   (cur_i),
        .rd_idx  (rd_idx),
        .rd_v    (rd_v),
        .rd_w    (rd_w),
        .spikes  (spikes),
        .busy    (busy),
        .done    (done)
    );

    // The DUT samples the current of the neuron it is working on.
    assign cur_i = cur_tab[cur_idx];

    always #5 clk = ~clk;

    // Last-resort guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- behavioural model ----------------
    function automatic int m_fit(input longint x);
`ifdef IZH_SATURATE_EN
        if (x > longint'(32'sh7FFFFFFF)) return 32'sh7FFFFFFF;
        if (x < longint'(32'sh80000000)) return 32'sh80000000;
`endif
        return int'(x);
    endfunction

    function automatic int m_mul(input int x, input int y);
        longint p;
        p = longint'(x) * longint'(y);
        return m_fit(p >>> Q);
    endfunction

    function automatic int m_add(input int x, input int y);
        return m_fit(longint'(x) + longint'(y));
    endfunction

    function automatic int m_sub(input int x, input int y);
        return m_fit(longint'(x) - longint'(y));
    endfunction

    task automatic modelSweep();
        for (int k = 0; k < NEURONS; k++) begin
            int v, w, poly;
            v = mv[k];
            w = mw[k];
            if (v >= int'(v_th)) begin
                mv[k]   = int'(c);
                mw[k]   = m_add(w, int'(d));
                mspk[k] = 1'b1;
            end else begin
                poly    = m_add(m_mul(m_mul(K004, v), v), m_mul(K5, v));
                poly    = m_add(m_sub(m_add(poly, K140), w), int'(cur_tab[k]));
                mv[k]   = m_add(v, m_mul(int'(step), poly));
                mw[k]   = m_add(w, m_mul(m_mul(int'(step), int'(a)),
                                         m_sub(m_mul(int'(b), v), w)));
                mspk[k] = 1'b0;
            end
        end
    endtask

    // ---------------- checking and stimulus tasks ----------------
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input int vth, input int st, input int aa,
                                 input int bb, input int cc, input int dd);
        v_th = vth;
        step = st;
        a    = aa;
        b    = bb;
        c    = cc;
        d    = dd;
    endtask

    // Asynchronous reset away from any edge, then INIT with the given state.
    task automatic doReset(input int vi, input int wi);
        v_init = vi;
        w_init = wi;
        #1 rst = 1'b0;
        #2;
        checkOutput("rst_busy",   busy,    1);
        checkOutput("rst_done",   done,    0);
        checkOutput("rst_idx",    cur_idx, 0);
        checkOutput("rst_spikes", spikes,  0);
        checkOutput("rst_rd_v",   rd_v,    0);
        checkOutput("rst_rd_w",   rd_w,    0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 1; i <= NEURONS; i++) begin
            @(posedge clk);
            #1;
            checkOutput("init_busy", busy, (i < NEURONS) ? 1 : 0);
            checkOutput("init_done", done, 0);
        end
        for (int k = 0; k < NEURONS; k++) begin
            mv[k] = vi;
            mw[k] = wi;
        end
        mspk = '0;
    endtask

    task automatic readOne(input int k, output logic signed [N-1:0] ov,
                           output logic signed [N-1:0] ow);
        rd_idx = IW'(k);
        @(posedge clk);
        #1;
        ov = rd_v;
        ow = rd_w;
    endtask

    task automatic readAll(input string tag);
        logic signed [N-1:0] ov, ow;
        for (int k = 0; k < NEURONS; k++) begin
            readOne(k, ov, ow);
            checkOutput({tag, "_v"}, ov, mv[k]);
            checkOutput({tag, "_w"}, ow, mw[k]);
        end
    endtask

    // One sweep: start is sampled at edge T0 and done must appear exactly
    // NEURONS edges later, for a single cycle.
    task automatic runSweep(input string tag);
        int lat;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput({tag, "_busy"}, busy, 1);
        lat = 0;
        while (done !== 1'b1 && lat < 4 * NEURONS) begin
            @(posedge clk);
            #1;
            lat++;
        end
        modelSweep();
        checkOutput({tag, "_lat"}, lat, NEURONS);
        checkOutput({tag, "_spikes"}, spikes, mspk);
        checkOutput({tag, "_idle"}, busy, 0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_donepulse"}, done, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic signed [N-1:0] ov, ow;
        int                  dones;
        logic                saw;

        rd_idx = '0;
        for (int k = 0; k < NEURONS; k++) cur_tab[k] = '0;
        applyStimulus(30 * ONE, 0, 0, 0, -65 * ONE, 8 * ONE);
        #1;

        // Power-on reset and INIT with v=35.0, w=1.0.
        doReset(35 * ONE, ONE);
        readAll("init");

        // Spike rule: every neuron is above threshold.
        runSweep("spike");
        checkOutput("spike_all", spikes, 8'hFF);
        readAll("spike");
        readOne(3, ov, ow);
        checkOutput("spike_v_lit", ov, $signed(32'hFFBF0000));
        checkOutput("spike_w_lit", ow, $signed(32'h00090000));

        // Zero step leaves sub-threshold neurons untouched.
        applyStimulus(30 * ONE, 0, 1311, 13107, -65 * ONE, 8 * ONE);
        runSweep("zero");
        checkOutput("zero_spikes", spikes, 0);
        readAll("zero");

        // Starts during the sweep and on the done cycle are all ignored.
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        modelSweep();
        dones = 0;
        saw   = 1'b0;
        for (int cyc = 1; cyc <= 3 * NEURONS; cyc++) begin
            start = (cyc == 2 || cyc == 4 || saw);
            @(posedge clk);
            #1;
            saw = done;
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        checkOutput("busystart_dones", dones, 1);
        checkOutput("busystart_idle", busy, 0);
        readAll("busystart");

        // Reset in the middle of a sweep reinitialises everything.
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        doReset(-65 * ONE, -13 * ONE);
        readAll("midreset");
        readOne(5, ov, ow);
        checkOutput("midreset_v_lit", ov, $signed(32'hFFBF0000));
        checkOutput("midreset_w_lit", ow, $signed(32'hFFF30000));

        // Per-neuron current: v[k] = 140.0 + k from a zero state.
        doReset(0, 0);
        applyStimulus(30 * ONE, ONE, 0, 13107, -65 * ONE, 8 * ONE);
        for (int k = 0; k < NEURONS; k++) cur_tab[k] = k * ONE;
        runSweep("cur");
        for (int k = 0; k < NEURONS; k++) begin
            readOne(k, ov, ow);
            checkOutput("cur_v", ov, (140 + k) * ONE);
            checkOutput("cur_w", ow, 0);
        end

        // Randomised currents over several timesteps of a regular-spiking cell.
        doReset(-int'($urandom_range(50 * ONE, 70 * ONE)), -13 * ONE);
        applyStimulus(30 * ONE, ONE / 2, 1311, 13107, -65 * ONE, 8 * ONE);
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < NEURONS; k++)
                cur_tab[k] = $urandom_range(0, 40 * ONE);
            runSweep("rand");
            readAll("rand");
        end

        // Overflow: v=1000.0 drives every term out of range.
        doReset(1000 * ONE, 0);
        applyStimulus(32'sh7FFFFFFF, ONE, 0, 0, 0, 0);
        for (int k = 0; k < NEURONS; k++) cur_tab[k] = '0;
        runSweep("sat");
        readAll("sat");
`ifdef IZH_SATURATE_EN
        readOne(0, ov, ow);
        checkOutput("sat_v_lit", ov, 32'sh7FFFFFFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
